// File: rtl/fft_fp_pkg.sv
// Shared IEEE-754 single-precision field definitions for the FFT datapath.
package fft_fp_pkg;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MAN_MSB = 22;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic                     sign;
        logic [EXP_MSB-EXP_LSB:0] exp;
        logic [MAN_MSB:0]         man;
    } fp32_t;

endpackage

// File: rtl/half_neg_core.sv
// Combinational x*(-1/2) on fp32 with zero/Inf/NaN handling.
// HALF_NEG_DENORM_EN selects gradual underflow instead of flush-to-zero.
module half_neg_core
    import fft_fp_pkg::*;
(
    input  logic [31:0] operand,
    output logic [31:0] result
);

    fp32_t op_f;
    fp32_t res_f;

    assign op_f = fp32_t'(operand);

    always_comb begin
        res_f      = '0;
        res_f.sign = ~op_f.sign;
        if (op_f.exp == EXP_MAX) begin
            // Inf stays Inf and NaN keeps its payload.
            res_f.exp = EXP_MAX;
            res_f.man = op_f.man;
        end else if (op_f.exp > 8'd1) begin
            res_f.exp = op_f.exp - 8'd1;
            res_f.man = op_f.man;
        end else begin
`ifdef HALF_NEG_DENORM_EN
            // Hidden bit (set only for e=1) shifts into the mantissa; the LSB is truncated.
            res_f.exp = 8'h00;
            res_f.man = {op_f.exp[0], op_f.man[MAN_MSB:1]};
`else
            res_f.exp = 8'h00;
            res_f.man = '0;
`endif
        end
    end

    assign result = res_f;

endmodule

// File: rtl/half_neg_arb.sv
// Round-robin shared scale-by-(-1/2) unit with a 2-entry tagged result FIFO.
// Build option: HALF_NEG_DENORM_EN (handled inside half_neg_core).
module half_neg_arb
    import fft_fp_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    output logic [31:0]          out_data,
    output logic [IDW-1:0]       out_id,
    input  logic                 out_ready
);

    localparam int DEPTH = 2;

    generate
        if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ) begin : g_bad_param
            $error("half_neg_arb: NREQ must be 2..8 and fit in IDW bits");
        end
    endgenerate

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant_p0;
    logic [IDW-1:0]  gnt_idx_p0;
    logic            gnt_any_p0;
    logic [31:0]     opnd_p0;
    logic [31:0]     res_p0;
    logic            accept_p0;
    logic            pop;
    logic            fifo_full;
    logic [1:0]      count;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [31:0]     fifo_data [DEPTH];
    logic [IDW-1:0]  fifo_id   [DEPTH];

    // Stage p0: round-robin grant, operand select and scaling
    always_comb begin
        grant_p0   = '0;
        gnt_idx_p0 = '0;
        gnt_any_p0 = 1'b0;
        // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any_p0 && req_valid[i] && (IDW'(i) >= ptr)) begin
                gnt_any_p0  = 1'b1;
                grant_p0[i] = 1'b1;
                gnt_idx_p0  = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any_p0 && req_valid[i] && (IDW'(i) < ptr)) begin
                gnt_any_p0  = 1'b1;
                grant_p0[i] = 1'b1;
                gnt_idx_p0  = IDW'(i);
            end
        end
    end

    always_comb begin
        opnd_p0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_p0[i]) begin
                opnd_p0 = req_data[32*i +: 32];
            end
        end
    end

    half_neg_core u_core (
        .operand (opnd_p0),
        .result  (res_p0)
    );

    assign fifo_full = (count == 2'd2);
    assign req_ready = (rst_n && !fifo_full) ? grant_p0 : '0;
    assign accept_p0 = |req_ready;

    // Stage p1: result FIFO, head drives the outputs
    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_id    = fifo_id[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_id[i]   <= '0;
            end
        end else begin
            if (accept_p0) begin
                ptr               <= (gnt_idx_p0 == IDW'(NREQ - 1)) ? '0 : gnt_idx_p0 + IDW'(1);
                fifo_data[wr_ptr] <= res_p0;
                fifo_id[wr_ptr]   <= gnt_idx_p0;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept_p0, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_half_neg_arb.sv
// Directed bench for half_neg_arb: latency, round-robin order, special operands,
// backpressure and mid-stream reset.
module tb_half_neg_arb;

    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [31:0]       out_data;
    logic [IDW-1:0]    out_id;
    logic              out_ready;
    logic [31:0]       lane_data [NREQ];

    int n_chk;
    int n_fail;

    assign req_data = {lane_data[2], lane_data[1], lane_data[0]};

    half_neg_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t spec_vec [8];
    logic [31:0] rr_exp [NREQ];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) lane_data[i] = '0;

        // Reset values
        step();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", out_data, 32'h0);
        check_eq("rst_out_id", 32'(out_id), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        reset_dut();

        // Single request from lane 1: 3.0 -> -1.5 next cycle
        lane_data[1] = 32'h40400000;
        req_valid    = 3'b010;
        out_ready    = 1'b1;
        #1;
        check_eq("single_ready", 32'(req_ready), 32'b010);
        step();
        req_valid = '0;
        check_eq("single_valid", 32'(out_valid), 32'd1);
        check_eq("single_data", out_data, 32'hBFC00000);
        check_eq("single_id", 32'(out_id), 32'd1);
        step();
        check_eq("single_drained", 32'(out_valid), 32'd0);

        // All lanes continuously valid from reset: ids 0,1,2,0,1,2
        reset_dut();
        lane_data[0] = 32'h3F800000; rr_exp[0] = 32'hBF000000;
        lane_data[1] = 32'h40000000; rr_exp[1] = 32'hBF800000;
        lane_data[2] = 32'hC0800000; rr_exp[2] = 32'h40000000;
        req_valid = 3'b111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq($sformatf("rr_valid%0d", k), 32'(out_valid), 32'd1);
            check_eq($sformatf("rr_id%0d", k), 32'(out_id), 32'(k % 3));
            check_eq($sformatf("rr_data%0d", k), out_data, rr_exp[k % 3]);
        end
        req_valid = '0;
        step();
        check_eq("rr_drained", 32'(out_valid), 32'd0);

        // Special operands through lane 0
        spec_vec[0] = '{32'h00000000, 32'h80000000};
        spec_vec[1] = '{32'h7F800000, 32'hFF800000};
        spec_vec[2] = '{32'h7FC00001, 32'hFFC00001};
        spec_vec[3] = '{32'h80000000, 32'h00000000};
        spec_vec[4] = '{32'h7F000000, 32'hFE800000};
`ifdef HALF_NEG_DENORM_EN
        spec_vec[5] = '{32'h00800000, 32'h80400000};
        spec_vec[6] = '{32'h00400001, 32'h80200000};
        spec_vec[7] = '{32'h00FFFFFF, 32'h807FFFFF};
`else
        spec_vec[5] = '{32'h00800000, 32'h80000000};
        spec_vec[6] = '{32'h00400001, 32'h80000000};
        spec_vec[7] = '{32'h00FFFFFF, 32'h80000000};
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            lane_data[0] = spec_vec[k].din;
            req_valid    = 3'b001;
            step();
            check_eq($sformatf("special_%h", spec_vec[k].din), out_data, spec_vec[k].dout);
        end
        req_valid = '0;
        step();

        // Backpressure: lanes 0 and 2 with out_ready low
        reset_dut();
        lane_data[0] = 32'h40400000;
        lane_data[1] = 32'h40000000;
        lane_data[2] = 32'h3F000000;
        req_valid = 3'b101;
        out_ready = 1'b0;
        #1;
        check_eq("bp_ready0", 32'(req_ready), 32'b001);
        step();
        check_eq("bp_ready1", 32'(req_ready), 32'b100);
        check_eq("bp_id_first", 32'(out_id), 32'd0);
        step();
        check_eq("bp_full_ready", 32'(req_ready), 32'b000);
        check_eq("bp_full_data", out_data, 32'hBFC00000);
        step();
        check_eq("bp_hold_ready", 32'(req_ready), 32'b000);
        check_eq("bp_hold_data", out_data, 32'hBFC00000);
        check_eq("bp_hold_id", 32'(out_id), 32'd0);
        out_ready = 1'b1;
        #1;
        check_eq("bp_pop_cycle_ready", 32'(req_ready), 32'b000);
        step();
        check_eq("bp_pop2_id", 32'(out_id), 32'd2);
        check_eq("bp_pop2_data", out_data, 32'hBE800000);
        check_eq("bp_resume_ready", 32'(req_ready), 32'b001);
        step();
        check_eq("bp_resume_id", 32'(out_id), 32'd0);
        check_eq("bp_resume_data", out_data, 32'hBFC00000);
        req_valid = '0;
        step();
        check_eq("bp_drained", 32'(out_valid), 32'd0);

        // Mid-stream reset with the FIFO full (ptr currently 1)
        req_valid = 3'b111;
        out_ready = 1'b0;
        step();
        step();
        check_eq("mr_full_valid", 32'(out_valid), 32'd1);
        check_eq("mr_full_id", 32'(out_id), 32'd1);
        check_eq("mr_full_ready", 32'(req_ready), 32'b000);
        rst_n = 1'b0;
        #1;
        check_eq("mr_async_valid", 32'(out_valid), 32'd0);
        check_eq("mr_async_ready", 32'(req_ready), 32'b000);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("mr_post_valid", 32'(out_valid), 32'd0);
        check_eq("mr_post_ready", 32'(req_ready), 32'b001);
        out_ready = 1'b1;
        step();
        check_eq("mr_post_id", 32'(out_id), 32'd0);
        check_eq("mr_post_data", out_data, 32'hBFC00000);
        req_valid = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
